rca_seq_adder: RTL

- Multi-cycle wide adder: adds two W = N*CHUNKS bit operands one N-bit chunk per clock.
- Feeds a single internal rca #(N) instance (ports A, B, Cin, Sum, Cout) and consumes its result; the rca carry-out is registered back into the next chunk's carry-in.
- Sits between the operand source and the result consumer; trades latency for area versus a W-bit rca.

---
 rtl/rca_seq_adder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rca_seq_adder.sv
// Multi-cycle W-bit adder: one N-bit chunk per clock through a single ripple-carry
// adder, with the chunk carry-out registered into the next chunk's carry-in.

module rca #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  logic [N:0] w_c;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign Sum[i]   = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign Cout = w_c[N];

endmodule

module rca_seq_adder #(
  parameter  int N      = 8,
  parameter  int CHUNKS = 4,
  localparam int W      = N * CHUNKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Sum,
  output logic         Cout
);

  localparam int            IW       = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [W-1:0]  r_opa;
  logic [W-1:0]  r_opb;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic          r_cout;
  logic [IW-1:0] r_idx;

  logic [N-1:0]  w_a_chunk;
  logic [N-1:0]  w_b_chunk;
  logic [N-1:0]  w_chunk_sum;
  logic          w_chunk_cout;
  logic          w_accept;
  logic          w_last;

  assign w_a_chunk = r_opa[int'(r_idx) * N +: N];
  assign w_b_chunk = r_opb[int'(r_idx) * N +: N];
  assign w_accept  = (r_state == IDLE) && start;
  assign w_last    = (r_idx == LAST_IDX);

  rca #(
    .N(N)
  ) u_rca (
    .A   (w_a_chunk),
    .B   (w_b_chunk),
    .Cin (r_carry),
    .Sum (w_chunk_sum),
    .Cout(w_chunk_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operands are only captured on an accepted start, so input changes while
  // RUN/DONE cannot disturb the in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_opa   <= A;
      r_opb   <= B;
      r_carry <= Cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[int'(r_idx) * N +: N] <= w_chunk_sum;
      r_carry                     <= w_chunk_cout;
      if (w_last) begin
        r_cout <= w_chunk_cout;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule
